// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit common-anode 7-segment scan scheduler.
// Frames arrive over valid/ready and are swapped in only at frame boundaries.
module seg_scan_ctrl #(
  parameter int SCAN_TICKS  = 100000,
  parameter int BLANK_TICKS = 1000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LD_VALID,
  output logic        LD_READY,
  input  logic [15:0] LD_DIGITS,
  input  logic [3:0]  LD_DP,
  input  logic        LZ_BLANK,
  output logic [11:0] DISP,
  output logic        FRAME_DONE
);

  localparam int MAXT = (SCAN_TICKS > BLANK_TICKS) ?
                        SCAN_TICKS : BLANK_TICKS;
  localparam int CW = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic          pend_full;
  logic [15:0]   pend_dig;
  logic [3:0]    pend_dp;
  logic          pend_lz;

  logic [15:0]   act_dig;
  logic [3:0]    act_dp;
  logic          act_lz;

  logic          accept;
  logic          commit;
  logic [2:0]    lead0;
  logic [3:0]    nib;
  logic [3:0]    anode;
  logic          dpb;
  logic          lzb;
  logic [11:0]   disp_nx;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign LD_READY = ~pend_full;
  assign accept   = LD_VALID & ~pend_full;
  assign commit   = FRAME_DONE & pend_full;

  // running "all zero so far" flags from the leftmost digit
  assign lead0[0] = (act_dig[15:12] == 4'd0);
  assign lead0[1] = lead0[0] & (act_dig[11:8] == 4'd0);
  assign lead0[2] = lead0[1] & (act_dig[7:4] == 4'd0);

  // scan sequencer: blank gap, then lit digit, advancing idx
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    cnt_nx     = cnt + CW'(1);
    FRAME_DONE = 1'b0;
    unique case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nx = ST_SHOW;
          cnt_nx   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == SCAN_LAST) begin
          state_nx   = ST_BLANK;
          cnt_nx     = '0;
          idx_nx     = idx + 2'd1;
          FRAME_DONE = (idx == 2'd3);
        end
      end
    endcase
  end

  // next display word for the digit selected after this edge
  always_comb begin
    nib   = act_dig[15:12];
    dpb   = act_dp[3];
    lzb   = act_lz & lead0[0];
    anode = 4'b0111;
    unique case (idx_nx)
      2'd0: begin
        nib   = act_dig[15:12];
        dpb   = act_dp[3];
        lzb   = act_lz & lead0[0];
        anode = 4'b0111;
      end
      2'd1: begin
        nib   = act_dig[11:8];
        dpb   = act_dp[2];
        lzb   = act_lz & lead0[1];
        anode = 4'b1011;
      end
      2'd2: begin
        nib   = act_dig[7:4];
        dpb   = act_dp[1];
        lzb   = act_lz & lead0[2];
        anode = 4'b1101;
      end
      2'd3: begin
        nib   = act_dig[3:0];
        dpb   = act_dp[0];
        lzb   = 1'b0;
        anode = 4'b1110;
      end
    endcase
    disp_nx = 12'hFFF;
    if (state_nx == ST_SHOW) begin
      disp_nx = {anode,
                 lzb ? 7'h7F : seg7(nib),
                 ~dpb};
    end
  end

  // scan state and registered display output
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_BLANK;
      idx   <= '0;
      cnt   <= '0;
      DISP  <= 12'hFFF;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      DISP  <= disp_nx;
    end
  end

  // pending/active frame buffers; swap only on frame boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_full <= 1'b0;
      pend_dig  <= '0;
      pend_dp   <= '0;
      pend_lz   <= 1'b0;
      act_dig   <= 16'hFFFF;
      act_dp    <= '0;
      act_lz    <= 1'b0;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_dig  <= LD_DIGITS;
      pend_dp   <= LD_DP;
      pend_lz   <= LZ_BLANK;
    end else if (commit) begin
      pend_full <= 1'b0;
      act_dig   <= pend_dig;
      act_dp    <= pend_dp;
      act_lz    <= pend_lz;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: bench for seg_scan_ctrl (SCAN=4, BLANK=2).
// Frame-position reference model plus directed spec vectors.
module tb_seg_scan_ctrl;

  logic        CLK;
  logic        RST;
  logic        LD_VALID;
  logic        LD_READY;
  logic [15:0] LD_DIGITS;
  logic [3:0]  LD_DP;
  logic        LZ_BLANK;
  logic [11:0] DISP;
  logic        FRAME_DONE;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(
    .SCAN_TICKS (4),
    .BLANK_TICKS(2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LD_VALID  (LD_VALID),
    .LD_READY  (LD_READY),
    .LD_DIGITS (LD_DIGITS),
    .LD_DP     (LD_DP),
    .LZ_BLANK  (LZ_BLANK),
    .DISP      (DISP),
    .FRAME_DONE(FRAME_DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic        lz;
  } frame_t;

  // model: n = cycles since reset; frame position = n mod 24
  int     n = 0;
  bit     pend_v = 0;
  frame_t pend;
  frame_t act = '{16'hFFFF, 4'h0, 1'b0};

  function automatic logic [6:0] segtab(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] exp_disp();
    int p, d, ph;
    logic [3:0] nb;
    logic [3:0] an;
    logic [3:0] one_hot;
    bit blank;
    p  = n % 24;
    d  = p / 6;
    ph = p % 6;
    if (ph < 2) return 12'hFFF;
    nb = act.dig[(3 - d) * 4 +: 4];
    blank = act.lz && (d < 3);
    for (int k = 0; k <= d; k++)
      if (act.dig[(3 - k) * 4 +: 4] != 4'd0) blank = 0;
    one_hot = 4'b1000;
    an = ~(one_hot >> d);
    return {an, blank ? 7'h7F : segtab(nb), ~act.dp[3 - d]};
  endfunction

  function automatic logic [13:0] exp_all();
    return {exp_disp(), !pend_v, (n % 24) == 23};
  endfunction

  task automatic mdl_edge(input bit rst);
    if (rst) begin
      n      = 0;
      pend_v = 0;
      act    = '{16'hFFFF, 4'h0, 1'b0};
    end else begin
      if ((n % 24) == 23 && pend_v) begin
        act    = pend;
        pend_v = 0;
      end else if (LD_VALID && !pend_v) begin
        pend   = '{LD_DIGITS, LD_DP, LZ_BLANK};
        pend_v = 1;
      end
      n++;
    end
  endtask

  task automatic tick(input bit rst);
    RST = rst;
    @(posedge CLK);
    mdl_edge(rst);
    #1;
  endtask

  task automatic do_reset();
    LD_VALID = 1'b0;
    tick(1'b1);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    LD_VALID  = 1'b0;
    LD_DIGITS = 16'h0;
    LD_DP     = 4'h0;
    LZ_BLANK  = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1);
    checks++;
    if ({DISP, LD_READY, FRAME_DONE} !== {12'hFFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got %h/%b/%b want fff/1/0",
               DISP, LD_READY, FRAME_DONE);
    end
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (DISP !== ((n < 2) ? 12'hFFF : 12'h7FF)) begin
        errors++;
        $display("FAIL reset_release n=%0d: got %h want %h",
                 n, DISP, (n < 2) ? 12'hFFF : 12'h7FF);
      end
      checks++;
      if ({DISP, LD_READY, FRAME_DONE} !== exp_all()) begin
        errors++;
        $display("FAIL reset_model n=%0d: got %h want %h",
                 n, {DISP, LD_READY, FRAME_DONE}, exp_all());
      end
      tick(1'b0);
    end
  endtask

  task automatic test_frames();
    frame_t      fr [4];
    logic [11:0] ex [4][4];
    fr[0] = '{16'h1234, 4'b0010, 1'b0};
    ex[0] = '{12'h79F, 12'hB25, 12'hD0C, 12'hE99};
    fr[1] = '{16'h0050, 4'b0000, 1'b1};
    ex[1] = '{12'h7FF, 12'hBFF, 12'hD49, 12'hE03};
    fr[2] = '{16'h0050, 4'b0000, 1'b0};
    ex[2] = '{12'h703, 12'hB03, 12'hD49, 12'hE03};
    fr[3] = '{16'hA9F0, 4'b0000, 1'b0};
    ex[3] = '{12'h7FF, 12'hB09, 12'hDFF, 12'hE03};
    for (int f = 0; f < 4; f++) begin
      do_reset();
      LD_VALID  = 1'b1;
      LD_DIGITS = fr[f].dig;
      LD_DP     = fr[f].dp;
      LZ_BLANK  = fr[f].lz;
      tick(1'b0);
      LD_VALID = 1'b0;
      while (n < 48) begin
        if (n >= 26 && n <= 44 && ((n - 26) % 6) == 0) begin
          checks++;
          if (DISP !== ex[f][(n - 26) / 6]) begin
            errors++;
            $display("FAIL frame%0d digit%0d: got %h want %h",
                     f, (n - 26) / 6, DISP, ex[f][(n - 26) / 6]);
          end
        end
        checks++;
        if ({DISP, LD_READY, FRAME_DONE} !== exp_all()) begin
          errors++;
          $display("FAIL frame%0d_model n=%0d: got %h want %h",
                   f, n, {DISP, LD_READY, FRAME_DONE}, exp_all());
        end
        tick(1'b0);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    LD_VALID  = 1'b1;
    LD_DIGITS = 16'h1234;
    LD_DP     = 4'h0;
    LZ_BLANK  = 1'b0;
    tick(1'b0);
    LD_DIGITS = 16'h5678;
    while (n < 52) begin
      if (n == 25) LD_VALID = 1'b0;
      if (n >= 1 && n <= 23) begin
        checks++;
        if (LD_READY !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall n=%0d: ready got %b want 0",
                   n, LD_READY);
        end
      end
      if (n == 23 || n == 24) begin
        checks++;
        if ({LD_READY, FRAME_DONE} !== ((n == 23) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL b2b_boundary n=%0d: rdy/fd got %b%b",
                   n, LD_READY, FRAME_DONE);
        end
      end
      if (n == 50) begin
        checks++;
        if (DISP !== 12'h749) begin
          errors++;
          $display("FAIL b2b_second: got %h want 749", DISP);
        end
      end
      checks++;
      if ({DISP, LD_READY, FRAME_DONE} !== exp_all()) begin
        errors++;
        $display("FAIL b2b_model n=%0d: got %h want %h",
                 n, {DISP, LD_READY, FRAME_DONE}, exp_all());
      end
      tick(1'b0);
    end
  endtask

  task automatic test_simul_accept();
    do_reset();
    LD_DIGITS = 16'h5678;
    LD_DP     = 4'h0;
    LZ_BLANK  = 1'b0;
    while (n < 52) begin
      LD_VALID = (n == 23);
      if (n == 26 || n == 50) begin
        checks++;
        if (DISP !== ((n == 26) ? 12'h7FF : 12'h749)) begin
          errors++;
          $display("FAIL simul n=%0d: got %h want %h",
                   n, DISP, (n == 26) ? 12'h7FF : 12'h749);
        end
      end
      checks++;
      if ({DISP, LD_READY, FRAME_DONE} !== exp_all()) begin
        errors++;
        $display("FAIL simul_model n=%0d: got %h want %h",
                 n, {DISP, LD_READY, FRAME_DONE}, exp_all());
      end
      tick(1'b0);
    end
    LD_VALID = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    LD_DIGITS = 16'h1234;
    LD_DP     = 4'h0;
    LZ_BLANK  = 1'b0;
    while (n < 39) begin
      LD_VALID  = (n == 0) || (n == 25);
      LD_DIGITS = (n == 25) ? 16'h5678 : 16'h1234;
      tick(1'b0);
    end
    LD_VALID = 1'b0;
    tick(1'b1);
    RST = 1'b0;
    checks++;
    if ({DISP, LD_READY, FRAME_DONE} !== {12'hFFF, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got %h/%b/%b want fff/1/0",
               DISP, LD_READY, FRAME_DONE);
    end
    while (n < 30) begin
      if (n == 2 || n == 26) begin
        checks++;
        if (DISP !== 12'h7FF) begin
          errors++;
          $display("FAIL reset_mid_blank n=%0d: got %h want 7ff",
                   n, DISP);
        end
      end
      checks++;
      if ({DISP, LD_READY, FRAME_DONE} !== exp_all()) begin
        errors++;
        $display("FAIL reset_mid_model n=%0d: got %h want %h",
                 n, {DISP, LD_READY, FRAME_DONE}, exp_all());
      end
      tick(1'b0);
    end
  endtask

  task automatic test_random();
    bit r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      LD_VALID = ($urandom % 3) == 0;
      for (int k = 0; k < 4; k++)
        LD_DIGITS[k * 4 +: 4] = ($urandom % 2) ? 4'd0 : 4'($urandom % 16);
      LD_DP    = 4'($urandom);
      LZ_BLANK = 1'($urandom);
      r = ($urandom % 200) == 0;
      tick(r);
      RST = 1'b0;
      checks++;
      if ({DISP, LD_READY, FRAME_DONE} !== exp_all()) begin
        errors++;
        $display("FAIL random i=%0d n=%0d: got %h want %h",
                 i, n, {DISP, LD_READY, FRAME_DONE}, exp_all());
      end
    end
    LD_VALID = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    LD_VALID  = 1'b0;
    LD_DIGITS = 16'h0;
    LD_DP     = 4'h0;
    LZ_BLANK  = 1'b0;
    test_reset();
    test_frames();
    test_back_to_back();
    test_simul_accept();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
